// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: stage enables/flushes,
// PC control, operand forwarding selects and saturating stall/redirect counters.
module pipeline_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             if_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_we,
    input  logic             id_mem_re,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ex_valid_q, ex_valid_d, ex_we_q, ex_we_d, ex_load_q, ex_load_d;
    logic [RA_W-1:0]  ex_rd_q, ex_rd_d;
    logic             mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
    logic [RA_W-1:0]  mem_rd_q, mem_rd_d;
    logic             wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [RA_W-1:0]  wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic run_ok, active, redir, lu, stall_inc;
    logic m_ex_a, m_mem_a, m_wb_a, m_ex_b, m_mem_b, m_wb_b;

    function automatic logic src_match(input logic v, input logic we,
                                       input logic [RA_W-1:0] rd,
                                       input logic [RA_W-1:0] rs, input logic used);
        return v & we & (rd != '0) & (rd == rs) & used;
    endfunction

    // Youngest producer wins; a load in EX has no result yet, so it cannot forward.
    function automatic logic [1:0] fwd_pick(input logic m_ex, input logic ex_load,
                                            input logic m_mem, input logic m_wb);
        if (m_ex && !ex_load) return 2'd1;
        if (m_mem)            return 2'd2;
        if (m_wb)             return 2'd3;
        return 2'd0;
    endfunction

    always_comb begin
        m_ex_a  = src_match(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs1, id_rs1_used);
        m_mem_a = src_match(mem_valid_q, mem_we_q, mem_rd_q, id_rs1, id_rs1_used);
        m_wb_a  = src_match(wb_valid_q,  wb_we_q,  wb_rd_q,  id_rs1, id_rs1_used);
        m_ex_b  = src_match(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs2, id_rs2_used);
        m_mem_b = src_match(mem_valid_q, mem_we_q, mem_rd_q, id_rs2, id_rs2_used);
        m_wb_b  = src_match(wb_valid_q,  wb_we_q,  wb_rd_q,  id_rs2, id_rs2_used);
        run_ok  = reset & run;
        active  = run_ok & (state_q != ST_IDLE) & ~mem_busy;
        redir   = ex_redirect & ex_valid_q;
        lu      = if_valid & ex_load_q & (m_ex_a | m_ex_b);
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!run)                    state_d = ST_IDLE;
        else if (state_q == ST_IDLE) state_d = ST_RUN;
        else if (mem_busy)           state_d = ST_MEM_WAIT;
        else                         state_d = ST_RUN;
    end

    always_comb begin
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        fwd_a       = 2'd0;
        fwd_b       = 2'd0;
        state       = ST_IDLE;
        if (reset) begin
            state = state_q;
            fwd_a = fwd_pick(m_ex_a, ex_load_q, m_mem_a, m_wb_a);
            fwd_b = fwd_pick(m_ex_b, ex_load_q, m_mem_b, m_wb_b);
        end
        if (active) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (redir) begin
                pc_en       = 1'b1;
                pc_sel      = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        if (mem_wb_en) begin
            wb_valid_d = mem_valid_q;
            wb_rd_d    = mem_rd_q;
            wb_we_d    = mem_we_q;
        end
        if (ex_mem_en) begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_we_d    = ex_we_q;
        end
        if (id_ex_en) begin
            ex_valid_d = if_valid & ~id_ex_flush;
            ex_rd_d    = id_ex_flush ? '0 : id_rd;
            ex_we_d    = id_reg_we & ~id_ex_flush;
            ex_load_d  = id_mem_re & ~id_ex_flush;
        end
        stall_inc   = (run_ok & mem_busy) | (active & ~redir & lu);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (active && redir && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then
// random stimulus compared every cycle against a stage-shift reference model.
module tb_pipeline_ctrl;
    localparam int RA_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int A_FREEZE = 0, A_REDIR = 1, A_STALL = 2, A_ADV = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, run, if_valid, id_rs1_used, id_rs2_used, id_reg_we, id_mem_re;
    logic ex_redirect, mem_busy;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [1:0] fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_mem_re(id_mem_re),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
    } slot_t;

    slot_t pipe [3];
    int    m_state = 0;
    int    m_stall = 0;
    int    m_flush = 0;
    bit    known   = 1'b0;

    function automatic bit hit(input int s, input logic [RA_W-1:0] rs, input logic used);
        return pipe[s].v && pipe[s].we && (pipe[s].rd != 0) && (pipe[s].rd == rs) && used;
    endfunction

    function automatic int model_fwd(input logic [RA_W-1:0] rs, input logic used);
        for (int s = 0; s < 3; s++) begin
            if (s == 0 && pipe[0].ld) continue;
            if (hit(s, rs, used)) return s + 1;
        end
        return 0;
    endfunction

    function automatic int model_action();
        if (!reset || !run || m_state == 0 || mem_busy) return A_FREEZE;
        if (ex_redirect && pipe[0].v) return A_REDIR;
        if (if_valid && pipe[0].ld && (hit(0, id_rs1, id_rs1_used) || hit(0, id_rs2, id_rs2_used)))
            return A_STALL;
        return A_ADV;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    always @(posedge clk) begin
        int act;
        slot_t nslot;
        if (!reset) begin
            for (int s = 0; s < 3; s++) pipe[s] <= '0;
            m_state <= 0;
            m_stall <= 0;
            m_flush <= 0;
            known   <= 1'b1;
        end else begin
            act = model_action();
            if ((run && mem_busy) || act == A_STALL) m_stall <= sat_inc(m_stall);
            if (act == A_REDIR) m_flush <= sat_inc(m_flush);
            if (act != A_FREEZE) begin
                nslot = '0;
                if (act == A_ADV) nslot = '{v: if_valid, rd: id_rd, we: id_reg_we, ld: id_mem_re};
                pipe[0] <= nslot;
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
            if (!run)              m_state <= 0;
            else if (m_state == 0) m_state <= 1;
            else                   m_state <= mem_busy ? 2 : 1;
        end
    end

    always @(negedge clk) begin
        int act;
        bit moving;
        if (known) begin
            act    = model_action();
            moving = (act != A_FREEZE);
            chk("cmp_pc_en",       pc_en,       (act == A_REDIR || act == A_ADV));
            chk("cmp_pc_sel",      pc_sel,      (act == A_REDIR));
            chk("cmp_if_id_en",    if_id_en,    (act == A_REDIR || act == A_ADV));
            chk("cmp_if_id_flush", if_id_flush, (act == A_REDIR));
            chk("cmp_id_ex_en",    id_ex_en,    moving);
            chk("cmp_id_ex_flush", id_ex_flush, (act == A_REDIR || act == A_STALL));
            chk("cmp_ex_mem_en",   ex_mem_en,   moving);
            chk("cmp_mem_wb_en",   mem_wb_en,   moving);
            chk("cmp_fwd_a",       fwd_a,       reset ? model_fwd(id_rs1, id_rs1_used) : 0);
            chk("cmp_fwd_b",       fwd_b,       reset ? model_fwd(id_rs2, id_rs2_used) : 0);
            chk("cmp_state",       state,       reset ? m_state : 0);
            chk("cmp_stall_cnt",   stall_cnt,   m_stall);
            chk("cmp_flush_cnt",   flush_cnt,   m_flush);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                          input logic u2, input int rd, input logic we, input logic re);
        if_valid    = v;
        id_rs1      = RA_W'(rs1);
        id_rs1_used = u1;
        id_rs2      = RA_W'(rs2);
        id_rs2_used = u2;
        id_rd       = RA_W'(rd);
        id_reg_we   = we;
        id_mem_re   = re;
    endtask

    task automatic clear_pipe();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
        repeat (3) step();
    endtask

    task automatic fwd_gap(input int gap, input int exp_sel);
        clear_pipe();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        step();
        for (int g = 0; g < gap; g++) begin
            set_id(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        set_id(1, 5, 1, 3, 1, 6, 1, 0);
        #2;
        chk("dir_fwd_gap", fwd_a, exp_sel);
        chk("dir_fwd_gap_b", fwd_b, 0);
        step();
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b1;
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
        set_id(1, 0, 1, 0, 1, 3, 1, 1);

        repeat (3) step();
        #2;
        chk("dir_rst_pc_en", pc_en, 0);
        chk("dir_rst_id_ex_en", id_ex_en, 0);
        chk("dir_rst_state", state, 0);
        chk("dir_rst_stall", stall_cnt, 0);
        chk("dir_rst_flush", flush_cnt, 0);

        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("dir_idle_state", state, 0);
        chk("dir_idle_pc_en", pc_en, 0);
        step();
        #2;
        chk("dir_run_state", state, 1);
        chk("dir_run_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);

        fwd_gap(0, 1);
        fwd_gap(1, 2);
        fwd_gap(2, 3);
        fwd_gap(3, 0);

        // lw x7 then add x8,x7,x7
        clear_pipe();
        set_id(1, 1, 1, 0, 0, 7, 1, 1);
        step();
        set_id(1, 7, 1, 7, 1, 8, 1, 0);
        #2;
        chk("dir_lu_pc_en", pc_en, 0);
        chk("dir_lu_if_id_en", if_id_en, 0);
        chk("dir_lu_id_ex_flush", id_ex_flush, 1);
        chk("dir_lu_stall_before", stall_cnt, 0);
        step();
        #2;
        chk("dir_lu_stall_after", stall_cnt, 1);
        chk("dir_lu_fwd_a", fwd_a, 2);
        chk("dir_lu_fwd_b", fwd_b, 2);
        chk("dir_lu_resume_pc_en", pc_en, 1);
        step();

        // redirect with coincident load-use
        clear_pipe();
        set_id(1, 1, 1, 0, 0, 7, 1, 1);
        step();
        set_id(1, 7, 1, 7, 1, 8, 1, 0);
        ex_redirect = 1'b1;
        #2;
        chk("dir_redir_pc_sel", pc_sel, 1);
        chk("dir_redir_flushes", {if_id_flush, id_ex_flush}, 2'b11);
        chk("dir_redir_pc_en", pc_en, 1);
        step();
        #2;
        chk("dir_redir_flush_cnt", flush_cnt, 1);
        chk("dir_redir_stall_cnt", stall_cnt, 1);
        chk("dir_redir_inv_flush", if_id_flush, 0);
        chk("dir_redir_inv_pc_sel", pc_sel, 0);
        step();
        #2;
        chk("dir_redir_inv_flush_cnt", flush_cnt, 1);
        ex_redirect = 1'b0;

        // mem_busy for 4 cycles with add x5 held in EX
        clear_pipe();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        step();
        set_id(1, 5, 1, 3, 1, 6, 1, 0);
        mem_busy = 1'b1;
        #2;
        chk("dir_busy_enables_c0", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
        chk("dir_busy_state_c0", state, 1);
        for (int c = 1; c < 4; c++) begin
            step();
            #2;
            chk("dir_busy_state", state, 2);
            chk("dir_busy_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
            chk("dir_busy_fwd_held", fwd_a, 1);
        end
        step();
        mem_busy = 1'b0;
        #2;
        chk("dir_busy_stall_cnt", stall_cnt, 5);
        chk("dir_busy_release_state", state, 2);
        chk("dir_busy_release_pc_en", pc_en, 1);
        chk("dir_busy_release_fwd", fwd_a, 1);
        step();
        #2;
        chk("dir_busy_resume_state", state, 1);

        // saturation then run drop mid MEM_WAIT
        mem_busy = 1'b1;
        repeat (12) step();
        #2;
        chk("dir_sat_stall", stall_cnt, CNT_MAX);
        step();
        #2;
        chk("dir_sat_hold", stall_cnt, CNT_MAX);
        chk("dir_sat_state", state, 2);
        run = 1'b0;
        step();
        #2;
        chk("dir_stop_state", state, 0);
        chk("dir_stop_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
        run = 1'b1;
        mem_busy = 1'b0;
        #1;
        chk("dir_restart_idle_pc_en", pc_en, 0);
        step();
        #2;
        chk("dir_restart_state", state, 1);

        for (int i = 0; i < 3000; i++) begin
            step();
            reset       = ($urandom_range(0, 199) != 0);
            run         = ($urandom_range(0, 19) != 0);
            mem_busy    = ($urandom_range(0, 6) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 4) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
